nanov_digit_alu: RTL and testbench

- Parametrised digit-serial ALU/compare unit for the next-generation nanoV datapath.
- Processes DIGIT bits per clock instead of one, trading area for throughput.
- Computes all RV32I register-register/immediate ALU ops plus branch compare flags over XLEN/DIGIT cycles.
- Emits each result digit as produced and holds the assembled parallel result and flags at completion.
- Sits between operand fetch (registers/immediate mux) and writeback/branch logic.

---
 rtl/nanov_digit_alu.sv | 218 +++++++++++++++++++++
 tb/tb_nanov_digit_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_digit_alu.sv
// Digit-serial RV32I ALU / branch-compare unit.
// Operands are latched on accept and consumed DIGIT bits per cycle, LSD first.
// Shift results are formed when the operands are accepted and then streamed out
// through the same digit pipe. Compare flags come from a dedicated a-b path.
module nanov_digit_alu #(
    parameter  int XLEN  = 32,
    parameter  int DIGIT = 4,
    localparam int N     = XLEN / DIGIT,
    localparam int SHW   = $clog2(XLEN),
    localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             busy,
    output logic             digit_valid,
    output logic [CW-1:0]    digit_idx,
    output logic [DIGIT-1:0] result_digit,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    typedef enum logic [2:0] {
        F_ADD  = 3'd0,
        F_SLL  = 3'd1,
        F_SLT  = 3'd2,
        F_SLTU = 3'd3,
        F_XOR  = 3'd4,
        F_SR   = 3'd5,
        F_OR   = 3'd6,
        F_AND  = 3'd7
    } funct3_t;

    state_t          r_state, w_next_state;
    funct3_t         r_f3;
    logic            r_alt;
    logic [XLEN-1:0] r_a_sh, r_b_sh, r_s_sh, r_acc, r_result;
    logic            r_a_msb, r_b_msb;
    logic            r_carry, r_cmp_carry, r_eq_acc;
    logic            r_eq, r_lt, r_ltu;
    logic [CW-1:0]   r_idx;

    logic            w_accept;
    logic            w_last;

    // Accept-side decode and shifter.
    funct3_t                w_in_f3;
    logic                   w_in_inv;
    logic [SHW-1:0]         w_s;
    logic signed [XLEN-1:0] w_sra;
    logic [XLEN-1:0]        w_shift_in;

    assign w_in_f3  = funct3_t'(op[2:0]);
    assign w_in_inv = ((w_in_f3 == F_ADD) && op[3]) || (w_in_f3 == F_SLT) || (w_in_f3 == F_SLTU);
    assign w_s      = b[SHW-1:0];
    // Kept as its own signed net so the arithmetic shift is not demoted to logical in a mixed mux.
    assign w_sra    = $signed(a) >>> w_s;

    // Select the full shifted operand for shift ops; other ops leave it unused.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_shift_in = '0;
        case (w_in_f3)
            F_SLL:   w_shift_in = a << w_s;
            F_SR:    w_shift_in = op[3] ? w_sra : (a >> w_s);
            default: w_shift_in = '0;
        endcase
    end

    // Per-digit arithmetic: op adder and the independent compare subtractor.
    logic [DIGIT-1:0] w_a_d, w_b_d, w_nb_d, w_b_op, w_sum, w_cmp_d, w_digit;
    logic [DIGIT:0]   w_sum_full, w_cmp_full;
    logic             w_inv, w_sum_co, w_cmp_co;
    logic             w_eq_fin, w_lt_fin, w_ltu_fin;
    logic [XLEN-1:0]  w_assembled, w_final;

    assign w_a_d      = r_a_sh[DIGIT-1:0];
    assign w_b_d      = r_b_sh[DIGIT-1:0];
    assign w_nb_d     = ~w_b_d;
    assign w_inv      = ((r_f3 == F_ADD) && r_alt) || (r_f3 == F_SLT) || (r_f3 == F_SLTU);
    assign w_b_op     = w_inv ? w_nb_d : w_b_d;
    assign w_sum_full = (DIGIT+1)'(w_a_d) + (DIGIT+1)'(w_b_op) + (DIGIT+1)'(r_carry);
    assign w_sum      = w_sum_full[DIGIT-1:0];
    assign w_sum_co   = w_sum_full[DIGIT];
    assign w_cmp_full = (DIGIT+1)'(w_a_d) + (DIGIT+1)'(w_nb_d) + (DIGIT+1)'(r_cmp_carry);
    assign w_cmp_d    = w_cmp_full[DIGIT-1:0];
    assign w_cmp_co   = w_cmp_full[DIGIT];

    // Flag values as they stand once the most significant digit is processed.
    assign w_eq_fin  = r_eq_acc & (w_cmp_d == '0);
    assign w_ltu_fin = ~w_cmp_co;
    assign w_lt_fin  = (r_a_msb ^ r_b_msb) ? r_a_msb : w_cmp_d[DIGIT-1];

    assign w_last = (r_idx == CW'(N - 1));

    // Result digit selection by operation.
    always_comb begin
        w_digit = '0;
        case (r_f3)
            F_ADD:         w_digit = w_sum;
            F_SLL, F_SR:   w_digit = r_s_sh[DIGIT-1:0];
            F_SLT, F_SLTU: w_digit = '0;
            F_XOR:         w_digit = w_a_d ^ w_b_d;
            F_OR:          w_digit = w_a_d | w_b_d;
            F_AND:         w_digit = w_a_d & w_b_d;
            default:       w_digit = '0;
        endcase
    end

    // New digit enters at the top of the accumulator; written as a wide shift so DIGIT == XLEN needs no empty slice.
    assign w_assembled = XLEN'({w_digit, r_acc} >> DIGIT);
    assign w_final     = (r_f3 == F_SLT)  ? XLEN'(w_lt_fin)  :
                         (r_f3 == F_SLTU) ? XLEN'(w_ltu_fin) : w_assembled;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // FSM next-state and status outputs; flush wins over both start and the final digit.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        digit_valid  = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                digit_valid = 1'b1;
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    done         = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load on accept, advance one digit per RUN cycle, commit result and flags on done.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: operand and carry registers are ordinary flops, so they are all cleared on reset.
        if (!rstn) begin
            r_f3        <= F_ADD;
            r_alt       <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_s_sh      <= '0;
            r_acc       <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_carry     <= 1'b0;
            r_cmp_carry <= 1'b0;
            r_eq_acc    <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
        end else if (w_accept) begin
            r_f3        <= w_in_f3;
            r_alt       <= op[3];
            r_a_sh      <= a;
            r_b_sh      <= b;
            r_s_sh      <= w_shift_in;
            r_acc       <= '0;
            r_a_msb     <= a[XLEN-1];
            r_b_msb     <= b[XLEN-1];
            r_carry     <= w_in_inv;
            r_cmp_carry <= 1'b1;
            r_eq_acc    <= 1'b1;
            r_idx       <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh      <= r_a_sh >> DIGIT;
            r_b_sh      <= r_b_sh >> DIGIT;
            r_s_sh      <= r_s_sh >> DIGIT;
            r_acc       <= w_assembled;
            r_carry     <= w_sum_co;
            r_cmp_carry <= w_cmp_co;
            r_eq_acc    <= r_eq_acc & (w_cmp_d == '0);
            r_idx       <= (w_last || flush) ? '0 : r_idx + CW'(1);
            if (done) begin
                r_result <= w_final;
                r_eq     <= w_eq_fin;
                r_lt     <= w_lt_fin;
                r_ltu    <= w_ltu_fin;
            end
        end
    end

    assign digit_idx    = r_idx;
    assign result_digit = digit_valid ? w_digit : '0;
    // Final values are forwarded during the done cycle and held in registers afterwards.
    assign result       = done ? w_final   : r_result;
    assign eq           = done ? w_eq_fin  : r_eq;
    assign lt           = done ? w_lt_fin  : r_lt;
    assign ltu          = done ? w_ltu_fin : r_ltu;

endmodule

// File: tb/tb_nanov_digit_alu.sv
// Self-checking bench for nanov_digit_alu: a 32/4 instance plus a 32/32 (single digit)
// instance, directed corner cases and random ops against an arithmetic reference model.
module tb_nanov_digit_alu;

    localparam int XLEN  = 32;
    localparam int DIGIT = 4;
    localparam int N     = XLEN / DIGIT;
    localparam int CW    = $clog2(N);

    logic             clk     = 1'b0;
    logic             rstn    = 1'b0;
    logic             start   = 1'b0;
    logic             start_w = 1'b0;
    logic             flush   = 1'b0;
    logic [3:0]       op      = '0;
    logic [XLEN-1:0]  a       = '0;
    logic [XLEN-1:0]  b       = '0;

    logic             busy, digit_valid, done, eq, lt, ltu;
    logic [CW-1:0]    digit_idx;
    logic [DIGIT-1:0] result_digit;
    logic [XLEN-1:0]  result;

    logic             busy_w, dv_w, done_w, eq_w, lt_w, ltu_w;
    logic [0:0]       idx_w;
    logic [XLEN-1:0]  rd_w, result_w;

    int              n_vec = 0;
    int              n_err = 0;
    logic [XLEN-1:0] last_exp = '0;

    always #5 clk = ~clk;

    nanov_digit_alu #(.XLEN(XLEN), .DIGIT(DIGIT)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .flush(flush), .op(op), .a(a), .b(b),
        .busy(busy), .digit_valid(digit_valid), .digit_idx(digit_idx),
        .result_digit(result_digit), .done(done), .result(result),
        .eq(eq), .lt(lt), .ltu(ltu)
    );

    nanov_digit_alu #(.XLEN(XLEN), .DIGIT(XLEN)) u_dut_wide (
        .clk(clk), .rstn(rstn), .start(start_w), .flush(1'b0), .op(op), .a(a), .b(b),
        .busy(busy_w), .digit_valid(dv_w), .digit_idx(idx_w),
        .result_digit(rd_w), .done(done_w), .result(result_w),
        .eq(eq_w), .lt(lt_w), .ltu(ltu_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: RV32I semantics straight from the operator definitions.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic e, output logic l, output logic lu);
        logic signed [31:0] sx;
        int s;
        sx = x;
        s  = int'(y[4:0]);
        e  = (x == y);
        lu = (x < y);
        l  = ($signed(x) < $signed(y));
        case (o[2:0])
            3'd0: r = o[3] ? x - y : x + y;
            3'd1: r = x << s;
            3'd2: r = {31'b0, l};
            3'd3: r = {31'b0, lu};
            3'd4: r = x ^ y;
            3'd5: begin
                if (o[3]) r = sx >>> s;
                else      r = x >> s;
            end
            3'd6: r = x | y;
            default: r = x & y;
        endcase
    endtask

    // disturb: 0 none, 1 second start at T+3, 2 flush at T+3, 3 async reset at T+5
    task automatic run_op(input logic [3:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b,
                          input int disturb, output logic [31:0] got);
        logic [31:0] e_res;
        logic        e_eq, e_lt, e_ltu, is_slt;
        int          main_done, wide_done;
        model(f_op, f_a, f_b, e_res, e_eq, e_lt, e_ltu);
        is_slt    = (f_op[2:0] == 3'd2) || (f_op[2:0] == 3'd3);
        main_done = 0;
        wide_done = 0;
        got       = '0;
        @(negedge clk);
        op = f_op; a = f_a; b = f_b; start = 1'b1; start_w = 1'b1;
        for (int cyc = 1; cyc <= N + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0; start_w = 1'b0;
            end
            if (digit_valid) begin
                check("digit_idx", digit_idx, cyc - 1);
                check("result_digit", result_digit, is_slt ? '0 : e_res[(cyc-1)*DIGIT +: DIGIT]);
            end
            if (done) begin
                main_done++;
                got = result;
                check("done_cycle", cyc, N);
                check("result", result, e_res);
                check("eq", eq, e_eq);
                check("lt", lt, e_lt);
                check("ltu", ltu, e_ltu);
            end
            if (done_w) begin
                wide_done++;
                check("wide_done_cycle", cyc, 1);
                check("wide_idx", idx_w, 0);
                check("wide_valid", dv_w & busy_w, 1);
                check("wide_digit", rd_w, is_slt ? '0 : e_res);
                check("wide_result", result_w, e_res);
                check("wide_flags", {eq_w, lt_w, ltu_w}, {e_eq, e_lt, e_ltu});
            end
            if (disturb == 2 && cyc == 4) begin
                check("flush_busy", busy, 0);
                check("flush_valid", digit_valid, 0);
            end
            if (cyc == 3 && disturb == 1) begin
                start = 1'b1; op = ~f_op; a = ~f_a; b = f_b + 32'd3;
            end
            if (cyc == 3 && disturb == 2) flush = 1'b1;
            if (cyc == 4) begin
                start = 1'b0; flush = 1'b0; op = f_op; a = f_a; b = f_b;
            end
            if (cyc == 5 && disturb == 3) begin
                rstn = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_valid_done", {digit_valid, done}, 0);
                check("rst_idx", digit_idx, 0);
                check("rst_result", result, 0);
                check("rst_flags", {eq, lt, ltu}, 0);
            end
            if (cyc == 6 && disturb == 3) rstn = 1'b1;
        end
        check("idle_after", busy, 0);
        check("wide_done_count", wide_done, 1);
        if (disturb >= 2) begin
            check("no_done", main_done, 0);
            if (disturb == 3) last_exp = '0;
            check("result_hold", result, last_exp);
        end else begin
            check("done_count", main_done, 1);
            last_exp = e_res;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir [12] = '{
        '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
        '{4'b1000, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE},
        '{4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001},
        '{4'b0011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000},
        '{4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
        '{4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000},
        '{4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
        '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0},
        '{4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0},
        '{4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
        '{4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0},
        '{4'b1001, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678}
    };

    initial begin
        logic [31:0] got, ra, rb;
        logic [3:0]  rop;
        // Reset state.
        #12;
        check("reset_status", {busy, digit_valid, done}, 0);
        check("reset_idx", digit_idx, 0);
        check("reset_result", result, 0);
        check("reset_flags", {eq, lt, ltu}, 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (dir[i]) begin
            run_op(dir[i].op, dir[i].a, dir[i].b, 0, got);
            check("directed", got, dir[i].exp);
        end

        // Start while busy must not disturb the running op.
        run_op(4'b0000, 32'd1, 32'd2, 1, got);
        check("busy_start_ignored", got, 32'd3);

        // Flush mid-op: no done, result keeps the last committed value.
        run_op(4'b1000, 32'd9, 32'd4, 2, got);

        // Flush and start together: nothing is accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 4'b0000; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy, 0);
        repeat (N + 1) @(negedge clk);
        check("flush_start_hold", result, last_exp);

        // Async reset mid-op, then a clean op afterwards.
        run_op(4'b0000, 32'd100, 32'd23, 3, got);
        run_op(4'b0000, 32'd7, 32'd8, 0, got);
        check("after_reset", got, 32'd15);

        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 3))
                1: rb = ra;
                2: ra = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                3: rb = 32'($urandom_range(0, 40));
                default: ;
            endcase
            run_op(rop, ra, rb, 0, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
